// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Address map, STATUS bit indices and decode helper for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam int          RAM_WORDS     = 64;
    localparam logic [31:0] GPIO_OUT_ADDR = 32'h0000_0800;
    localparam logic [31:0] GPIO_IN_ADDR  = 32'h0000_0804;
    localparam logic [31:0] CYCLE_ADDR    = 32'h0000_0808;
    localparam logic [31:0] STATUS_ADDR   = 32'h0000_080C;

    localparam int STATUS_MISALIGNED = 0;
    localparam int STATUS_UNMAPPED   = 1;

    typedef enum logic [2:0] {
        SEL_NONE     = 3'd0,
        SEL_RAM      = 3'd1,
        SEL_GPIO_OUT = 3'd2,
        SEL_GPIO_IN  = 3'd3,
        SEL_CYCLE    = 3'd4,
        SEL_STATUS   = 3'd5
    } sel_e;

    // Takes the word address (byte address bits [31:2]); byte offset never affects decode.
    function automatic sel_e decode(input logic [29:0] word_addr);
        sel_e sel;
        sel = SEL_NONE;
        if (word_addr[29:10] != 20'd0)
            sel = SEL_NONE;
        else if (word_addr[9:6] == RAM_BASE[11:8])
            sel = SEL_RAM;
        else if (word_addr == GPIO_OUT_ADDR[31:2])
            sel = SEL_GPIO_OUT;
        else if (word_addr == GPIO_IN_ADDR[31:2])
            sel = SEL_GPIO_IN;
        else if (word_addr == CYCLE_ADDR[31:2])
            sel = SEL_CYCLE;
        else if (word_addr == STATUS_ADDR[31:2])
            sel = SEL_STATUS;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// Module      : dmem_if
// Description : Core-side data-memory bus between the pipeline and responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_if;
    logic        we_dm;
    logic [31:0] alu_out;
    logic [31:0] wd_dm;
    logic [31:0] rd_dm;

    modport master (output we_dm, output alu_out, output wd_dm, input  rd_dm);
    modport slave  (input  we_dm, input  alu_out, input  wd_dm, output rd_dm);
endinterface

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// Module      : dmem_ram
// Description : 64x32 storage, combinational read, synchronous write, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ram
    import dmem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        we,
    input  wire logic [5:0]  waddr,
    input  wire logic [31:0] wdata,
    input  wire logic [5:0]  raddr,
    output logic      [31:0] rdata
);

    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Memory-mapped RAM, GPIO, cycle counter and sticky STATUS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_if.slave            bus,
    input  wire logic [31:0] gpio_in,
    output logic      [31:0] gpio_out,
    output logic             bus_err
);

    sel_e        w_sel;
    logic        w_aligned;
    logic        w_wr_ok;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [1:0]  w_status_next;

    logic [31:0] r_gpio_out;
    logic [31:0] r_cycle;
    logic [1:0]  r_status;
    logic        r_bus_err;
    logic [31:0] r_sync1;
    logic [31:0] r_sync2;

    assign w_sel     = decode(bus.alu_out[31:2]);
    assign w_aligned = (bus.alu_out[1:0] == 2'b00);
    assign w_wr_ok   = bus.we_dm & w_aligned & ~rst;
    assign w_ram_we  = w_wr_ok & (w_sel == SEL_RAM);

    dmem_ram u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (bus.alu_out[7:2]),
        .wdata (bus.wd_dm),
        .raddr (bus.alu_out[7:2]),
        .rdata (w_ram_rdata)
    );

    // Only one write per cycle, so a set and a clear of the same bit never collide.
    always_comb begin
        w_status_next = r_status;
        if (bus.we_dm) begin
            if (!w_aligned)
                w_status_next[STATUS_MISALIGNED] = 1'b1;
            else if (w_sel == SEL_NONE)
                w_status_next[STATUS_UNMAPPED] = 1'b1;
            else if (w_sel == SEL_STATUS)
                w_status_next = r_status & ~bus.wd_dm[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_out <= 32'd0;
            r_cycle    <= 32'd0;
            r_status   <= 2'b00;
            r_bus_err  <= 1'b0;
            r_sync1    <= 32'd0;
            r_sync2    <= 32'd0;
        end else begin
            r_sync1   <= gpio_in;
            r_sync2   <= r_sync1;
            r_status  <= w_status_next;
            r_bus_err <= |w_status_next;
            if (w_wr_ok && w_sel == SEL_GPIO_OUT)
                r_gpio_out <= bus.wd_dm;
            if (w_wr_ok && w_sel == SEL_CYCLE)
                r_cycle <= 32'd0;
            else
                r_cycle <= r_cycle + 32'd1;
        end
    end

    always_comb begin
        bus.rd_dm = 32'd0;
        case (w_sel)
            SEL_RAM:      bus.rd_dm = w_ram_rdata;
            SEL_GPIO_OUT: bus.rd_dm = r_gpio_out;
            SEL_GPIO_IN:  bus.rd_dm = r_sync2;
            SEL_CYCLE:    bus.rd_dm = r_cycle;
            SEL_STATUS:   bus.rd_dm = {30'd0, r_status};
            default:      bus.rd_dm = 32'd0;
        endcase
    end

    assign gpio_out = r_gpio_out;
    assign bus_err  = r_bus_err;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: we_dm  input  1  core data-memory write enable.
REQ-005 Port: alu_out  input  32  core byte address (EX/MEM ALU result).
REQ-006 Port: wd_dm  input  32  core write data.
REQ-007 Port: rd_dm  output  32  read data returned to core.
REQ-008 Port: gpio_in  input  32  asynchronous external inputs.
REQ-009 Port: gpio_out  output  32  registered external outputs.
REQ-010 Port: bus_err  output  1  OR of STATUS sticky bits.

Function
REQ-011 The address map SHALL be as follows:
- Byte 0x000-0x0FC: RAM, 64 words, indexed by alu_out[7:2].
- 0x800: GPIO_OUT, read/write.
- 0x804: GPIO_IN, read-only.
- 0x808: CYCLE, read-only; any write clears it.
- 0x80C: STATUS, write-1-to-clear.
REQ-012 Any address with alu_out[31:12]!=0 SHALL be unmapped.
REQ-013 Any address not listed in REQ-011 SHALL be unmapped.
REQ-014 Reads SHALL be combinational and side-effect free, with rd_dm valid in the same cycle as alu_out; there is no read enable.
REQ-015 Reads of unmapped addresses SHALL return 32'h0.
REQ-016 For read decode, alu_out[1:0] SHALL be ignored.
REQ-017 Writes SHALL take effect on the rising edge where we_dm=1; a read in the following cycle returns the new value.
REQ-018 A write with alu_out[1:0]!=0 SHALL be suppressed, with no state change, and SHALL set STATUS[0] (misaligned).
REQ-019 An aligned write to an unmapped address SHALL be dropped and SHALL set STATUS[1] (unmapped).
REQ-020 Writes to GPIO_IN SHALL be dropped without setting any flag.
REQ-021 CYCLE SHALL be a 32-bit free-running counter that increments by 1 every cycle and wraps from 0xFFFFFFFF to 0x00000000.
REQ-022 A write to CYCLE SHALL make its next value 0, regardless of wd_dm; counting resumes from there.
REQ-023 GPIO_IN reads SHALL return gpio_in through a 2-flop synchronizer, so latency is 2 cycles.
REQ-024 A STATUS write SHALL clear each bit where wd_dm[i]=1.
REQ-025 STATUS[31:2] SHALL read 0.
REQ-026 If an error-setting write coincides with a clear of the same bit, set SHALL win; these cannot occur in the same cycle, since one write occurs per cycle.
REQ-027 A misaligned write to STATUS SHALL set STATUS[0] and SHALL NOT clear any bit.
REQ-028 bus_err SHALL equal STATUS[0] | STATUS[1], registered, so it rises in the cycle after the faulting write.

Reset
REQ-029 On rst=1 at a rising edge the following SHALL reset:
- gpio_out = 0
- CYCLE = 0
- STATUS = 0
- bus_err = 0
- synchronizer flops = 0
REQ-030 RAM contents SHALL NOT be reset and are undefined until written.
REQ-031 While rst=1, writes SHALL be ignored.
REQ-032 Reset asserted in the same cycle as a write SHALL discard that write.
REQ-033 In the first cycle after rst deasserts, CYCLE SHALL read 0, and 1 the cycle after.

Structure
REQ-034 Package dmem_pkg SHALL hold the following:
- address constants (RAM_BASE, RAM_WORDS=64, GPIO_OUT_ADDR, GPIO_IN_ADDR, CYCLE_ADDR, STATUS_ADDR)
- STATUS bit indices
- the address-decode select enum
REQ-035 A single sub-module dmem_ram SHALL implement the 64x32 storage, with combinational read, synchronous write, and no reset.
REQ-036 Decode, registers, counter and read mux SHALL be in dmem_responder.

Verification
REQ-037 Write 0xDEADBEEF to 0x004, then read 0x004 next cycle -> rd_dm=0xDEADBEEF; read 0x044 (unwritten) -> no side effects, and 0x004 is unchanged.
REQ-038 Write 0x000000A5 to 0x800 -> gpio_out=0x000000A5 next cycle; reading 0x800 returns 0x000000A5. Set gpio_in=0x1234 -> reading 0x804 returns 0x1234 starting 2 cycles later.
REQ-039 Release reset, read 0x808 for 3 cycles -> 0,1,2. Write 0x808 (wd_dm=0x55) -> next read 0. Force CYCLE to 0xFFFFFFFF in sim -> next 0x00000000.
REQ-040 Error flags:
- Write to 0x006 -> RAM word 1 is unchanged, STATUS=0x1, bus_err=1 next cycle.
- Write to 0x900 -> STATUS=0x3.
- Write 0x1 to 0x80C -> STATUS=0x2, bus_err stays 1.
- Write 0x2 to 0x80C -> STATUS=0, bus_err=0.
REQ-041 Assert rst in the same cycle as a write of 0xFF to 0x800 -> gpio_out=0 and STATUS=0; CYCLE restarts at 0.
